// File: rtl/seq_mult_param.sv
// seq_mult_param
// Parametrised sequential shift-add multiplier. The control FSM and the
// datapath live in one block. Operands are converted to magnitudes when
// accepted, multiplied unsigned one bit per clock, and the sign is applied
// once when the result is written.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      level request, accepted only in IDLE
//   abort      synchronous cancel, higher priority than start
//   is_signed  1 = two's-complement operands, sampled at accept
//   a, b       multiplicand / multiplier, sampled at accept
//   busy       high while iterating (RUN)
//   done       high while the result is being presented (DONE)
//   product    result register, written only on entry to DONE
//   cycles     iteration count of the last completed operation
module seq_mult_param #(
   parameter int WIDTH      = 8,
   parameter int EARLY_TERM = 1,
   parameter int CW         = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [CW-1:0]        cycles
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] ITER_MAX = CW'(WIDTH);

   logic [1:0]         r_state;
   logic [2*WIDTH-1:0] r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_iter;
   logic               r_neg;
   logic [2*WIDTH-1:0] r_product;
   logic [CW-1:0]      r_cycles;

   logic [WIDTH-1:0]   w_aMag;
   logic [WIDTH-1:0]   w_bMag;
   logic               w_term;
   logic [2*WIDTH-1:0] w_accNext;
   logic [2*WIDTH-1:0] w_result;

   // Operand magnitudes. Negating the most negative value wraps to
   // 2^(WIDTH-1), which is exactly its magnitude as an unsigned number.
   always_comb begin
      w_aMag = a;
      w_bMag = b;
      if (is_signed && a[WIDTH-1]) begin
         w_aMag = -a;
      end
      if (is_signed && b[WIDTH-1]) begin
         w_bMag = -b;
      end
   end

   // Termination test, partial-product accumulation and the signed result.
   // With early termination the loop ends as soon as no multiplier bits
   // remain; otherwise it always runs a full WIDTH iterations.
   always_comb begin
      w_term    = (EARLY_TERM != 0) ? (r_mb == '0) : (r_iter == ITER_MAX);
      w_accNext = r_mb[0] ? (r_acc + r_ma) : r_acc;
      w_result  = r_neg ? -r_acc : r_acc;
   end

   // Control FSM and datapath registers. product and cycles are written
   // only on the RUN->DONE transition so the previous result stays
   // readable while a new operation is in progress or after an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ma      <= '0;
         r_mb      <= '0;
         r_acc     <= '0;
         r_iter    <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
         r_cycles  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!abort && start) begin
                  r_ma    <= {{WIDTH{1'b0}}, w_aMag};
                  r_mb    <= w_bMag;
                  r_acc   <= '0;
                  r_iter  <= '0;
                  r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
               end else if (w_term) begin
                  r_product <= w_result;
                  r_cycles  <= r_iter;
                  r_state   <= S_DONE;
               end else begin
                  r_acc  <= w_accNext;
                  r_ma   <= r_ma << 1;
                  r_mb   <= r_mb >> 1;
                  r_iter <= r_iter + CW'(1);
               end
            end
            S_DONE: begin
               if (abort || !start) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Moore outputs straight from the state and result registers.
   always_comb begin
      busy    = (r_state == S_RUN);
      done    = (r_state == S_DONE);
      product = r_product;
      cycles  = r_cycles;
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param
// Self-checking bench for seq_mult_param at WIDTH=8. One instance runs with
// early termination, a second without. Results are compared against a
// reference that multiplies the operands with plain integer arithmetic.
module tb_seq_mult_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1;
   logic        start0;
   logic        abort;
   logic        isSigned;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy1;
   logic        done1;
   logic        busy0;
   logic        done0;
   logic [15:0] product1;
   logic [15:0] product0;
   logic [3:0]  cycles1;
   logic [3:0]  cycles0;

   int errors = 0;
   int checks = 0;
   logic [15:0] lastProd1 = '0;
   logic [15:0] lastProd0 = '0;
   logic [3:0]  lastCyc1  = '0;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   seq_mult_param #(.WIDTH(8), .EARLY_TERM(1)) dut (
      .clk(clk), .rst(rst), .start(start1), .abort(abort),
      .is_signed(isSigned), .a(a), .b(b),
      .busy(busy1), .done(done1), .product(product1), .cycles(cycles1)
   );

   seq_mult_param #(.WIDTH(8), .EARLY_TERM(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort),
      .is_signed(isSigned), .a(a), .b(b),
      .busy(busy0), .done(done0), .product(product0), .cycles(cycles0)
   );

   // Reference product: interpret operands as integers and multiply.
   function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y,
                                              input logic s);
      longint px;
      longint py;
      longint p;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      p  = px * py;
      return p[15:0];
   endfunction

   // Reference iteration count: bit length of |b|, or the full width.
   function automatic int refCycles(input logic [7:0] y, input logic s, input int et);
      int mag;
      if (et == 0) return 8;
      mag = (s && y[7]) ? (256 - int'(y)) : int'(y);
      return $clog2(mag + 1);
   endfunction

   function automatic logic curDone(input int et);
      return (et != 0) ? done1 : done0;
   endfunction

   function automatic logic curBusy(input int et);
      return (et != 0) ? busy1 : busy0;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation and wait (bounded) for done, scrambling the
   // operand inputs while the multiplier is running.
   task automatic applyStimulus(input int et, input logic [7:0] x, input logic [7:0] y,
                                input logic s, output int lat, output int busyCnt);
      a = x;
      b = y;
      isSigned = s;
      abort = 1'b0;
      if (et != 0) start1 = 1'b1;
      else start0 = 1'b1;
      tick;
      lat = 0;
      busyCnt = curBusy(et) ? 1 : 0;
      checkOutput("holdDuringRun", (et != 0) ? product1 : product0,
                  (et != 0) ? lastProd1 : lastProd0);
      while (!curDone(et) && lat < 40) begin
         a = 8'($urandom);
         b = 8'($urandom);
         isSigned = 1'($urandom);
         tick;
         lat++;
         if (curBusy(et)) busyCnt++;
      end
   endtask

   task automatic runOp(input int et, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input string tag);
      int lat;
      int busyCnt;
      logic [15:0] expP;
      int expN;
      expP = refProduct(x, y, s);
      expN = refCycles(y, s, et);
      applyStimulus(et, x, y, s, lat, busyCnt);
      checkOutput({tag, "_done"}, 32'(curDone(et)), 32'd1);
      checkOutput({tag, "_prod"}, (et != 0) ? product1 : product0, 32'(expP));
      checkOutput({tag, "_cyc"}, (et != 0) ? cycles1 : cycles0, 32'(expN));
      checkOutput({tag, "_lat"}, 32'(lat), 32'(expN + 1));
      checkOutput({tag, "_busy"}, 32'(busyCnt), 32'(expN + 1));
      if (et != 0) begin
         lastProd1 = expP;
         lastCyc1  = 4'(expN);
      end else begin
         lastProd0 = expP;
      end
   endtask

   task automatic finishOp(input int et);
      if (et != 0) start1 = 1'b0;
      else start0 = 1'b0;
      tick;
      checkOutput("idleDone", 32'(curDone(et)), 32'd0);
      checkOutput("idleBusy", 32'(curBusy(et)), 32'd0);
   endtask

   // Directed sequence followed by random operands on both instances.
   initial begin
      rst = 1'b1;
      start1 = 1'b0;
      start0 = 1'b0;
      abort = 1'b0;
      isSigned = 1'b0;
      a = '0;
      b = '0;
      tick;
      checkOutput("rstBusy", 32'(busy1), 32'd0);
      checkOutput("rstDone", 32'(done1), 32'd0);
      checkOutput("rstProd", 32'(product1), 32'd0);
      checkOutput("rstCyc", 32'(cycles1), 32'd0);
      rst = 1'b0;
      tick;

      runOp(1, 8'd13, 8'd11, 1'b0, "u13x11");   finishOp(1);
      runOp(1, 8'hFD, 8'd5, 1'b1, "sM3x5");     finishOp(1);
      runOp(1, 8'h80, 8'h80, 1'b1, "sMinSq");   finishOp(1);
      runOp(1, 8'hFF, 8'hFF, 1'b0, "u255sq");   finishOp(1);
      runOp(1, 8'd77, 8'd0, 1'b0, "bZero");     finishOp(1);
      runOp(1, 8'h05, 8'hFF, 1'b1, "s5xM1");    finishOp(1);
      runOp(0, 8'd77, 8'd0, 1'b0, "bZeroNoET"); finishOp(0);
      runOp(0, 8'h80, 8'h80, 1'b1, "sMinSqNoET"); finishOp(0);

      // Holding start through DONE must not restart the multiplier.
      runOp(1, 8'd9, 8'd6, 1'b0, "holdStart");
      for (int i = 0; i < 5; i++) begin
         tick;
         checkOutput("holdDone", 32'(done1), 32'd1);
         checkOutput("holdBusy", 32'(busy1), 32'd0);
      end
      finishOp(1);
      runOp(1, 8'd2, 8'd3, 1'b0, "u2x3");
      finishOp(1);

      // Abort two edges into 200*100: back to IDLE, old result kept.
      a = 8'd200;
      b = 8'd100;
      isSigned = 1'b0;
      start1 = 1'b1;
      tick;
      tick;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      start1 = 1'b0;
      checkOutput("abortBusy", 32'(busy1), 32'd0);
      checkOutput("abortProd", 32'(product1), 32'(lastProd1));
      checkOutput("abortCyc", 32'(cycles1), 32'(lastCyc1));
      for (int i = 0; i < 4; i++) begin
         checkOutput("abortNoDone", 32'(done1), 32'd0);
         tick;
      end

      // Asynchronous reset in the middle of RUN, between clock edges.
      a = 8'd200;
      b = 8'd255;
      start1 = 1'b1;
      tick;
      tick;
      #2 rst = 1'b1;
      start1 = 1'b0;
      #1;
      checkOutput("midRstBusy", 32'(busy1), 32'd0);
      checkOutput("midRstDone", 32'(done1), 32'd0);
      checkOutput("midRstProd", 32'(product1), 32'd0);
      checkOutput("midRstCyc", 32'(cycles1), 32'd0);
      #1 rst = 1'b0;
      lastProd1 = '0;
      lastProd0 = '0;
      lastCyc1 = '0;
      tick;
      runOp(1, 8'd7, 8'd9, 1'b0, "u7x9");
      finishOp(1);

      // Random operands and modes on both instances.
      for (int i = 0; i < 20; i++) begin
         runOp(1, 8'($urandom), 8'($urandom), 1'($urandom), "rndET");
         finishOp(1);
      end
      for (int i = 0; i < 8; i++) begin
         runOp(0, 8'($urandom), 8'($urandom), 1'($urandom), "rndNoET");
         finishOp(0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-add multiplier with the control unit and datapath in one block.
- Generalises the fixed-width multiplier control with:
  - configurable operand width
  - per-operation signed/unsigned mode
  - optional early termination
  - synchronous abort
  - held result register
  - iteration-count output
- Sits between a requesting controller (start/done level handshake) and downstream logic consuming product.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- EARLY_TERM, 1, 1 = stop when the remaining multiplier is zero; 0 = always run WIDTH iterations.
- CW, $clog2(WIDTH+1), width of the cycles output; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level request; accepted in IDLE.
- abort  in  1  synchronous cancel; higher priority than start.
- is_signed  in  1  1 = two's-complement operands; sampled at accept.
- a  in  WIDTH  multiplicand; sampled at accept.
- b  in  WIDTH  multiplier; sampled at accept.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- product  out  2*WIDTH  result register; changes only on entry to DONE or on reset.
- cycles  out  CW  iteration count n of the last completed operation.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, any state, including mid-operation): state=IDLE, busy=0, done=0, product=0, cycles=0; all internal registers cleared.
- Moore outputs: busy=(state==RUN), done=(state==DONE).
- IDLE:
  - abort=1: stay IDLE.
  - Else start=1 (accept edge E0):
    - ma = zero-extended |a| (2*WIDTH bits).
    - mb = |b| (WIDTH bits).
    - acc=0, iter=0.
    - neg = is_signed & (a[MSB] ^ b[MSB]).
    - Go to RUN.
  - |x| is the two's-complement magnitude when is_signed=1 and x[MSB]=1; otherwise x unchanged.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1), which fits in WIDTH unsigned bits.
- RUN, each edge, in priority order:
  - abort=1: go to IDLE; product and cycles unchanged.
  - Termination (EARLY_TERM=1: mb==0; EARLY_TERM=0: iter==WIDTH): product = neg ? -acc : acc (mod 2^(2*WIDTH)), cycles=iter, go to DONE.
  - Otherwise, iterate:
    - if mb[0], acc = acc + ma;
    - ma = ma<<1;
    - mb = mb>>1;
    - iter = iter+1.
- Iteration count n:
  - EARLY_TERM=1: n = bit index of the MSB of |b| plus 1, or 0 when |b|=0.
  - EARLY_TERM=0: n = WIDTH.
  - Sign of b does not affect n beyond |b|.
- Latency: done rises after edge E0+n+1. Worst case is WIDTH+1 edges.
- DONE:
  - abort=1: go to IDLE.
  - Else start=1: stay DONE; no restart.
  - Else start=0: go to IDLE.
  - A new operation therefore requires start to drop and re-assert.
- product and cycles hold their values through IDLE and RUN until the next DONE entry, so the previous result stays readable during a new operation.
- Operand, is_signed and start changes during RUN have no effect.
- acc never overflows 2*WIDTH bits. The signed result is exact for all operand pairs, including (-2^(W-1))^2 = 2^(2W-2).

Test Plan:
- Unsigned 13*11, W=8, EARLY_TERM=1 -> product=0x008F, cycles=4, done after E0+5, busy high for 5 cycles.
- Signed -3*5 -> product=0xFFF1, cycles=3. Signed -128*-128 -> product=0x4000, cycles=8. Unsigned 255*255 -> product=0xFE01, cycles=8.
- b=0 -> product=0, cycles=0, done after E0+1. Repeat with EARLY_TERM=0 -> cycles=8, done after E0+9.
- Hold start high through DONE for 5 cycles -> done stays 1, no restart. Drop start -> IDLE next edge. Re-raise with 2*3 -> product=0x0006.
- Pulse abort at E0+2 while computing 200*100 -> IDLE next edge, done never rises, product still holds the previous result.
- Assert rst mid-RUN between edges -> busy=0, done=0, product=0, cycles=0 immediately. Next start with 7*9 -> product=0x003F.
